// File: rtl/led_bank_pwm_pkg.sv
// Shared register map and reset constants for the memory-mapped LED bank.
package led_pkg;

  localparam logic [2:0] LED_OFF_DATA      = 3'd0;
  localparam logic [2:0] LED_OFF_SET       = 3'd1;
  localparam logic [2:0] LED_OFF_CLR       = 3'd2;
  localparam logic [2:0] LED_OFF_TGL       = 3'd3;
  localparam logic [2:0] LED_OFF_BLINK_EN  = 3'd4;
  localparam logic [2:0] LED_OFF_BLINK_DIV = 3'd5;
  localparam logic [2:0] LED_OFF_PWM_DUTY  = 3'd6;
  localparam logic [2:0] LED_OFF_STATUS    = 3'd7;

  localparam int LED_STAT_PHASE  = 0;
  localparam int LED_STAT_PWM_ON = 1;

  // Full brightness out of reset; callers take the low PWM_W bits.
  localparam logic [15:0] LED_PWM_DUTY_RST = 16'hFFFF;

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink phase generator: half-period of reload_i+1 cycles, restartable by load_i.
module led_blink_prescaler #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] reload_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         phase_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  // A load wins over the terminal-count reload so a new divisor restarts cleanly.
  always_comb begin
    cnt_d   = cnt_q - W'(1);
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = load_val_i;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = reload_i;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/led_bank_pwm.sv
// LED output bank: DATA/SET/CLR/TGL register file, per-LED blink and global PWM dimming.
module led_bank_pwm
  import led_pkg::*;
#(
  parameter int NUM_LEDS    = 16,
  parameter int BLINK_DIV_W = 24,
  parameter int PWM_W       = 8
) (
  input  logic                led_clk,
  input  logic                led_rst,
  input  logic [31:0]         led_addr,
  input  logic                led_we,
  input  logic [31:0]         led_raw_wdata,
  output logic [31:0]         led_rdata,
  output logic [NUM_LEDS-1:0] led_wdata
);

  localparam logic [PWM_W-1:0] DUTY_RST = LED_PWM_DUTY_RST[PWM_W-1:0];

  logic [2:0]             off;
  logic [NUM_LEDS-1:0]    wd_led;
  logic [NUM_LEDS-1:0]    data_q, data_d;
  logic [NUM_LEDS-1:0]    blink_en_q, blink_en_d;
  logic [BLINK_DIV_W-1:0] blink_div_q, blink_div_d;
  logic [PWM_W-1:0]       pwm_duty_q, pwm_duty_d;
  logic [PWM_W-1:0]       pwm_cnt_q;
  logic [NUM_LEDS-1:0]    led_q, led_d;
  logic                   div_load;
  logic                   blink_phase;
  logic                   pwm_on;
  logic                   unused_addr, unused_wdata;

  assign off          = led_addr[4:2];
  assign wd_led       = led_raw_wdata[NUM_LEDS-1:0];
  assign div_load     = led_we && (off == LED_OFF_BLINK_DIV);
  assign unused_addr  = ^led_addr;
  assign unused_wdata = ^led_raw_wdata;

  always_comb begin
    data_d      = data_q;
    blink_en_d  = blink_en_q;
    blink_div_d = blink_div_q;
    pwm_duty_d  = pwm_duty_q;
    if (led_we) begin
      unique case (off)
        LED_OFF_DATA:      data_d      = wd_led;
        LED_OFF_SET:       data_d      = data_q | wd_led;
        LED_OFF_CLR:       data_d      = data_q & ~wd_led;
        LED_OFF_TGL:       data_d      = data_q ^ wd_led;
        LED_OFF_BLINK_EN:  blink_en_d  = wd_led;
        LED_OFF_BLINK_DIV: blink_div_d = led_raw_wdata[BLINK_DIV_W-1:0];
        LED_OFF_PWM_DUTY:  pwm_duty_d  = led_raw_wdata[PWM_W-1:0];
        default: ;
      endcase
    end
  end

  led_blink_prescaler #(.W(BLINK_DIV_W)) u_blink (
    .clk_i      (led_clk),
    .rst_i      (led_rst),
    .reload_i   (blink_div_q),
    .load_i     (div_load),
    .load_val_i (led_raw_wdata[BLINK_DIV_W-1:0]),
    .phase_o    (blink_phase)
  );

  // All-ones duty is forced on so full brightness has no dark cycle at wrap.
  assign pwm_on = (pwm_duty_q == {PWM_W{1'b1}}) || (pwm_cnt_q < pwm_duty_q);

  assign led_d = data_q & ~(blink_en_q & ~{NUM_LEDS{blink_phase}}) & {NUM_LEDS{pwm_on}};

  always_ff @(posedge led_clk or posedge led_rst) begin
    if (led_rst) begin
      data_q      <= '0;
      blink_en_q  <= '0;
      blink_div_q <= '0;
      pwm_duty_q  <= DUTY_RST;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      data_q      <= data_d;
      blink_en_q  <= blink_en_d;
      blink_div_q <= blink_div_d;
      pwm_duty_q  <= pwm_duty_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_W'(1);
      led_q       <= led_d;
    end
  end

  assign led_wdata = led_q;

  always_comb begin
    led_rdata = '0;
    unique case (off)
      LED_OFF_DATA, LED_OFF_SET,
      LED_OFF_CLR, LED_OFF_TGL: led_rdata[NUM_LEDS-1:0]    = data_q;
      LED_OFF_BLINK_EN:         led_rdata[NUM_LEDS-1:0]    = blink_en_q;
      LED_OFF_BLINK_DIV:        led_rdata[BLINK_DIV_W-1:0] = blink_div_q;
      LED_OFF_PWM_DUTY:         led_rdata[PWM_W-1:0]       = pwm_duty_q;
      LED_OFF_STATUS: begin
        led_rdata[LED_STAT_PHASE]  = blink_phase;
        led_rdata[LED_STAT_PWM_ON] = pwm_on;
      end
      default: ;
    endcase
  end

endmodule
